// File: rtl/raiden_pkg.sv
// rtl/raiden_pkg.sv - shared matrix geometry, position and slot-state types
//
// Purpose : common definitions for the player bullet engine and its slots.
// Contents: ROW_W/COL_W/MATRIX_N constants, pos_t {row, col},
//           slot_state_t {SLOT_IDLE, SLOT_FLY}.
package raiden_pkg;

  localparam int ROW_W    = 3;
  localparam int COL_W    = 3;
  localparam int MATRIX_N = 8;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } pos_t;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FLY  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/bullet_slot.sv
// rtl/bullet_slot.sv - one in-flight player bullet
//
// Purpose : holds a single bullet; spawns at PLAYER_COL-1 on load, moves one
//           column toward 0 per step, retires on a miss (col 0 at step) or on
//           a collision with the enemy.
// Ports   : clk, rst (async active-low)
//           load       - claim this slot (only honoured while IDLE)
//           step       - game tick
//           player_row - spawn row
//           enemy_row/enemy_col - current enemy position
//           valid      - slot is FLY
//           pos        - registered bullet position
//           match      - combinational collision with the enemy this cycle
module bullet_slot
  import raiden_pkg::*;
#(
  parameter int PLAYER_COL = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [ROW_W-1:0] player_row,
  input  logic [ROW_W-1:0] enemy_row,
  input  logic [COL_W-1:0] enemy_col,
  output logic             valid,
  output pos_t             pos,
  output logic             match
);

  localparam logic [COL_W-1:0] SPAWN_COL = COL_W'(PLAYER_COL - 1);

  slot_state_t r_state;
  pos_t        r_pos;

  assign valid = (r_state == SLOT_FLY);
  assign pos   = r_pos;
  assign match = valid && (r_pos.row == enemy_row) && (r_pos.col == enemy_col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SLOT_IDLE;
      r_pos   <= '0;
    end else if (r_state == SLOT_IDLE) begin
      // A slot loaded this cycle is IDLE, so it never sees the same-cycle step.
      if (load) begin
        r_state   <= SLOT_FLY;
        r_pos.row <= player_row;
        r_pos.col <= SPAWN_COL;
      end
    end else begin
      // Collision takes priority and suppresses the step.
      if (match) begin
        r_state <= SLOT_IDLE;
      end else if (step) begin
        if (r_pos.col == '0) begin
          r_state <= SLOT_IDLE;
        end else begin
          r_pos.col <= r_pos.col - COL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bullet_engine.sv
// rtl/bullet_engine.sv - player bullet launcher, mover and collision reporter
//
// Purpose : accepts fire requests into the lowest free slot, rate-limits them
//           with a tick-based cooldown, and reports enemy hits (hit drives the
//           enemy block's attacked input).
// Ports   : clk, rst (async active-low), step_tick, fire, player_row,
//           enemy_row, enemy_col -> fire_ack, hit, hit_row, hit_col,
//           bullet_valid[NUM_SLOTS], bullet_row/bullet_col[3*NUM_SLOTS]
//           (slot i at [3i+2:3i]), hit_count[8].
// Options : BULLET_HIT_COUNT_EN builds the saturating hit counter; otherwise
//           hit_count is tied to 0.
module bullet_engine
  import raiden_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int PLAYER_COL = 6,
  parameter int COOLDOWN   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_tick,
  input  logic                   fire,
  input  logic [ROW_W-1:0]       player_row,
  input  logic [ROW_W-1:0]       enemy_row,
  input  logic [COL_W-1:0]       enemy_col,
  output logic                   fire_ack,
  output logic                   hit,
  output logic [ROW_W-1:0]       hit_row,
  output logic [COL_W-1:0]       hit_col,
  output logic [NUM_SLOTS-1:0]   bullet_valid,
  output logic [3*NUM_SLOTS-1:0] bullet_row,
  output logic [3*NUM_SLOTS-1:0] bullet_col,
  output logic [7:0]             hit_count
);

  localparam int              CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  generate
    if (PLAYER_COL < 1 || PLAYER_COL > 7) begin : g_bad_player_col
      $error("bullet_engine: PLAYER_COL must be in 1..7");
    end
    if (NUM_SLOTS < 1 || NUM_SLOTS > 8) begin : g_bad_num_slots
      $error("bullet_engine: NUM_SLOTS must be in 1..8");
    end
  endgenerate

  logic [NUM_SLOTS-1:0] w_valid;
  logic [NUM_SLOTS-1:0] w_match;
  logic [NUM_SLOTS-1:0] w_sel_oh;
  logic [NUM_SLOTS-1:0] w_load;
  pos_t                 w_pos [NUM_SLOTS];
  logic                 w_free_any;
  logic                 w_accept;
  logic                 w_hit_any;
  pos_t                 w_hit_pos;

  logic                 r_fire_ack;
  logic                 r_hit;
  logic [ROW_W-1:0]     r_hit_row;
  logic [COL_W-1:0]     r_hit_col;
  logic [CD_W-1:0]      r_cd;

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      bullet_slot #(
        .PLAYER_COL (PLAYER_COL)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load[g]),
        .step       (step_tick),
        .player_row (player_row),
        .enemy_row  (enemy_row),
        .enemy_col  (enemy_col),
        .valid      (w_valid[g]),
        .pos        (w_pos[g]),
        .match      (w_match[g])
      );
      assign bullet_row[3*g +: 3] = w_pos[g].row;
      assign bullet_col[3*g +: 3] = w_pos[g].col;
    end
  endgenerate

  // Scan high to low so the last write leaves the lowest-index candidate.
  always_comb begin
    w_free_any = 1'b0;
    w_sel_oh   = '0;
    w_hit_any  = 1'b0;
    w_hit_pos  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free_any = 1'b1;
        w_sel_oh   = '0;
        w_sel_oh[i] = 1'b1;
      end
      if (w_match[i]) begin
        w_hit_any = 1'b1;
        w_hit_pos = w_pos[i];
      end
    end
  end

  // Free-ness is taken from the registered valid, so a slot retiring this
  // cycle is only reusable from the next one.
  assign w_accept = fire && (r_cd == '0) && w_free_any;
  assign w_load   = w_accept ? w_sel_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fire_ack <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_row  <= '0;
      r_hit_col  <= '0;
      r_cd       <= '0;
    end else begin
      r_fire_ack <= w_accept;
      r_hit      <= w_hit_any;
      if (w_hit_any) begin
        r_hit_row <= w_hit_pos.row;
        r_hit_col <= w_hit_pos.col;
      end
      if (w_accept) begin
        r_cd <= CD_LOAD;
      end else if (step_tick && (r_cd != '0)) begin
        r_cd <= r_cd - CD_W'(1);
      end
    end
  end

`ifdef BULLET_HIT_COUNT_EN
  logic [7:0] r_hit_count;

  // Advances on the same edge that raises hit, saturating at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count <= '0;
    end else if (w_hit_any && (r_hit_count != 8'hFF)) begin
      r_hit_count <= r_hit_count + 8'd1;
    end
  end

  assign hit_count = r_hit_count;
`else
  assign hit_count = '0;
`endif

  assign fire_ack     = r_fire_ack;
  assign hit          = r_hit;
  assign hit_row      = r_hit_row;
  assign hit_col      = r_hit_col;
  assign bullet_valid = w_valid;

endmodule

// File: tb/tb_bullet_engine.sv
// tb/tb_bullet_engine.sv - directed self-checking bench for bullet_engine
module tb_bullet_engine;

`ifdef BULLET_HIT_COUNT_EN
  localparam int HC_EN = 1;
`else
  localparam int HC_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        step_tick, fire;
  logic [2:0]  player_row, enemy_row, enemy_col;
  logic        fire_ack, hit;
  logic [2:0]  hit_row, hit_col;
  logic [3:0]  bullet_valid;
  logic [11:0] bullet_row, bullet_col;
  logic [7:0]  hit_count;

  logic        step2, fire2;
  logic [2:0]  prow2, erow2, ecol2;
  logic        fire_ack2, hit2;
  logic [2:0]  hit_row2, hit_col2;
  logic [3:0]  valid2;
  logic [11:0] brow2, bcol2;
  logic [7:0]  hit_count2;

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clk = ~clk;

  bullet_engine #(.NUM_SLOTS(4), .PLAYER_COL(6), .COOLDOWN(2)) u_dut (
    .clk(clk), .rst(rst), .step_tick(step_tick), .fire(fire),
    .player_row(player_row), .enemy_row(enemy_row), .enemy_col(enemy_col),
    .fire_ack(fire_ack), .hit(hit), .hit_row(hit_row), .hit_col(hit_col),
    .bullet_valid(bullet_valid), .bullet_row(bullet_row), .bullet_col(bullet_col),
    .hit_count(hit_count)
  );

  // Zero-cooldown instance: lets all slots fill without ticks and lets two
  // slots sit on the same square.
  bullet_engine #(.NUM_SLOTS(4), .PLAYER_COL(6), .COOLDOWN(0)) u_dut2 (
    .clk(clk), .rst(rst), .step_tick(step2), .fire(fire2),
    .player_row(prow2), .enemy_row(erow2), .enemy_col(ecol2),
    .fire_ack(fire_ack2), .hit(hit2), .hit_row(hit_row2), .hit_col(hit_col2),
    .bullet_valid(valid2), .bullet_row(brow2), .bullet_col(bcol2),
    .hit_count(hit_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic t);
    fire = f;
    step_tick = t;
    @(posedge clk);
    #1;
    fire = 1'b0;
    step_tick = 1'b0;
  endtask

  task automatic cyc2(input logic f);
    fire2 = f;
    @(posedge clk);
    #1;
    fire2 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fire = 1'b0; step_tick = 1'b0;
    player_row = 3'd0; enemy_row = 3'd7; enemy_col = 3'd7;
    fire2 = 1'b0; step2 = 1'b0; prow2 = 3'd2; erow2 = 3'd7; ecol2 = 3'd7;
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", bullet_valid, 4'h0);
    chk("reset_row", bullet_row, 12'h000);
    chk("reset_col", bullet_col, 12'h000);
    chk("reset_fire_ack", fire_ack, 1'b0);
    chk("reset_hit", hit, 1'b0);
    chk("reset_hit_pos", {hit_row, hit_col}, 6'h00);
    chk("reset_hit_count", hit_count, 8'd0);
    rst = 1'b1;

    // Fire at row 3, then a refused fire while cooldown is 2.
    player_row = 3'd3;
    cyc(1'b1, 1'b0);
    chk("fire1_ack", fire_ack, 1'b1);
    chk("fire1_valid", bullet_valid, 4'h1);
    chk("fire1_row", bullet_row[2:0], 3'd3);
    chk("fire1_col", bullet_col[2:0], 3'd5);
    cyc(1'b1, 1'b0);
    chk("cooldown_refuse_ack", fire_ack, 1'b0);
    chk("cooldown_refuse_valid", bullet_valid, 4'h1);

    // Enemy at (3,1): four ticks bring the bullet to col 1, hit next cycle.
    enemy_row = 3'd3; enemy_col = 3'd1;
    repeat (4) cyc(1'b0, 1'b1);
    chk("tick4_col", bullet_col[2:0], 3'd1);
    chk("tick4_no_hit_yet", hit, 1'b0);
    cyc(1'b0, 1'b0);
    chk("hit_pulse", hit, 1'b1);
    chk("hit_pos", {hit_row, hit_col}, {3'd3, 3'd1});
    chk("hit_slot_idle", bullet_valid, 4'h0);
    chk("hit_count_1", hit_count, 8'(HC_EN));
    cyc(1'b0, 1'b0);
    chk("hit_one_cycle", hit, 1'b0);

    // Miss: row 5 vs enemy row 2, col 0 after 5 ticks, retired on the 6th.
    enemy_row = 3'd2; enemy_col = 3'd7;
    player_row = 3'd5;
    cyc(1'b1, 1'b0);
    chk("miss_fire_ack", fire_ack, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1);
      seen = seen | hit;
    end
    chk("miss_col0", bullet_col[2:0], 3'd0);
    chk("miss_valid_at_col0", bullet_valid, 4'h1);
    cyc(1'b0, 1'b1);
    seen = seen | hit;
    chk("miss_retired", bullet_valid, 4'h0);
    cyc(1'b0, 1'b0);
    seen = seen | hit;
    chk("miss_no_hit", seen, 1'b0);

    // Two immediate hits at the spawn square (4,5).
    enemy_row = 3'd4; enemy_col = 3'd5;
    player_row = 3'd4;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("spawn_hit_a", {hit, hit_row, hit_col}, {1'b1, 3'd4, 3'd5});
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("spawn_hit_b", hit, 1'b1);
    chk("hit_count_3", hit_count, 8'(3 * HC_EN));

    // Asynchronous reset between edges while a bullet is in flight.
    enemy_row = 3'd7; enemy_col = 3'd7;
    player_row = 3'd1;
    repeat (2) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("preflight_col", bullet_col[2:0], 3'd4);
    chk("preflight_valid", bullet_valid, 4'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", bullet_valid, 4'h0);
    chk("async_rst_hit", hit, 1'b0);
    chk("async_rst_count", hit_count, 8'd0);
    @(posedge clk);
    #1;
    chk("rst_held_valid", bullet_valid, 4'h0);
    chk("rst_held_hit", hit, 1'b0);
    rst = 1'b1;

    // Zero-cooldown instance: fill all four slots, fifth refused.
    for (int i = 0; i < 4; i++) begin
      cyc2(1'b1);
      chk("fill_ack", fire_ack2, 1'b1);
      chk("fill_valid", valid2, 32'((1 << (i + 1)) - 1));
    end
    cyc2(1'b1);
    chk("full_refuse_ack", fire_ack2, 1'b0);
    chk("full_refuse_valid", valid2, 4'hF);
    chk("full_rows", brow2, 12'h492);
    chk("full_cols", bcol2, 12'hB6D);

    // All four slots match together: one pulse, all retire.
    erow2 = 3'd2; ecol2 = 3'd5;
    cyc2(1'b0);
    chk("multi_hit", hit2, 1'b1);
    chk("multi_hit_pos", {hit_row2, hit_col2}, {3'd2, 3'd5});
    chk("multi_retire", valid2, 4'h0);
    chk("multi_count", hit_count2, 8'(HC_EN));
    cyc2(1'b0);
    chk("multi_single_pulse", hit2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
